// File: rtl/mnist_result_collector_if.sv
// Handshake bundle between the network core / readback host and the result collector.
// master drives frame/score/readback-select; slave returns prediction and status.
interface mnist_result_collector_if #(
  parameter int SCORE_WIDTH = 32
);
  logic                   frame_start;
  logic [SCORE_WIDTH-1:0] result;
  logic                   result_valid;
  logic [3:0]             rd_idx;
  logic [3:0]             digit;
  logic [SCORE_WIDTH-1:0] max_score;
  logic                   done;
  logic                   busy;
  logic                   timeout;
  logic [SCORE_WIDTH-1:0] rd_score;

  modport master (
    output frame_start, result, result_valid, rd_idx,
    input  digit, max_score, done, busy, timeout, rd_score
  );

  modport slave (
    input  frame_start, result, result_valid, rd_idx,
    output digit, max_score, done, busy, timeout, rd_score
  );
endinterface

// File: rtl/mnist_result_collector.sv
// Collects NUM_CLASSES signed class scores per frame, tracks the running argmax and
// publishes the predicted digit; abandons a frame that stalls for TIMEOUT_CYCLES.
module mnist_result_collector #(
  parameter int NUM_CLASSES    = 10,
  parameter int SCORE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  mnist_result_collector_if.slave bus
);
  localparam int CW = $clog2(NUM_CLASSES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e                        state_q;
  logic [CW-1:0]                 cnt_q;
  logic [TW-1:0]                 tmr_q;
  logic signed [SCORE_WIDTH-1:0] score_q [NUM_CLASSES];
  logic signed [SCORE_WIDTH-1:0] run_max_q;
  logic [3:0]                    run_idx_q;
  logic [3:0]                    digit_q;
  logic signed [SCORE_WIDTH-1:0] max_q;
  logic                          done_q;
  logic                          to_q;

  logic                          new_wins;
  logic signed [SCORE_WIDTH-1:0] max_d;
  logic [3:0]                    idx_d;
  logic                          last_valid;
  logic                          tmr_expired;

  // First score of a frame loads unconditionally; later ones need strictly greater, so ties keep the lower index.
  assign new_wins    = (cnt_q == '0) || ($signed(bus.result) > run_max_q);
  assign max_d       = new_wins ? $signed(bus.result) : run_max_q;
  assign idx_d       = new_wins ? 4'(cnt_q) : run_idx_q;
  assign last_valid  = bus.result_valid && (cnt_q == CW'(NUM_CLASSES - 1));
  assign tmr_expired = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      digit_q   <= 4'hF;
      max_q     <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) score_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      to_q   <= 1'b0;
      if (bus.frame_start) begin
        // frame_start overrides any coincident result_valid; stored scores survive until overwritten
        state_q   <= COLLECT;
        cnt_q     <= '0;
        tmr_q     <= '0;
        run_max_q <= '0;
        run_idx_q <= '0;
      end else if (state_q == COLLECT) begin
        if (bus.result_valid) begin
          score_q[cnt_q] <= bus.result;
          cnt_q          <= cnt_q + 1'b1;
          run_max_q      <= max_d;
          run_idx_q      <= idx_d;
        end
        if (last_valid) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          digit_q <= idx_d;
          max_q   <= max_d;
          tmr_q   <= '0;
        end else if (tmr_expired) begin
          state_q <= IDLE;
          to_q    <= 1'b1;
          digit_q <= 4'hF;
          max_q   <= '0;
          tmr_q   <= '0;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.rd_score = '0;
    if ({28'd0, bus.rd_idx} < NUM_CLASSES) bus.rd_score = score_q[bus.rd_idx];
  end

  assign bus.digit     = digit_q;
  assign bus.max_score = max_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == COLLECT);
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_mnist_result_collector.sv
// Drives a default-timeout and a short-timeout collector with identical stimulus and
// checks both every cycle against a frame-level reference model plus directed sequences.
module tb_mnist_result_collector;
  localparam int N  = 10;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fs, rv;
  logic [SW-1:0] res;
  logic [3:0]    ridx;

  always #5 clk = ~clk;

  mnist_result_collector_if #(.SCORE_WIDTH(SW)) ifa ();
  mnist_result_collector_if #(.SCORE_WIDTH(SW)) ifb ();

  assign ifa.frame_start = fs;  assign ifb.frame_start = fs;
  assign ifa.result_valid = rv; assign ifb.result_valid = rv;
  assign ifa.result = res;      assign ifb.result = res;
  assign ifa.rd_idx = ridx;     assign ifb.rd_idx = ridx;

  mnist_result_collector #(.NUM_CLASSES(N), .SCORE_WIDTH(SW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  mnist_result_collector #(.NUM_CLASSES(N), .SCORE_WIDTH(SW), .TIMEOUT_CYCLES(50)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int dcnt [2];
  int tcnt [2];

  // Reference model: 0 idle, 1 collecting, 2 complete
  int          tov [2] = '{5000000, 50};
  int          m_st [2];
  int          m_cnt [2];
  int          m_start [2];
  logic [SW-1:0] m_sc [2][16];
  logic [3:0]  m_dig [2];
  logic [SW-1:0] m_max [2];
  logic        m_done [2];
  logic        m_to [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_st[i] = 0; m_cnt[i] = 0; m_start[i] = 0;
    m_dig[i] = 4'hF; m_max[i] = '0; m_done[i] = 1'b0; m_to[i] = 1'b0;
    for (int j = 0; j < 16; j++) m_sc[i][j] = '0;
  endtask

  task automatic model_step(input int i);
    int best;
    if (!rst_n) begin model_reset(i); return; end
    m_done[i] = 1'b0;
    m_to[i]   = 1'b0;
    if (fs) begin
      m_st[i] = 1; m_cnt[i] = 0; m_start[i] = cyc;
    end else if (m_st[i] == 1) begin
      if (rv) begin m_sc[i][m_cnt[i]] = res; m_cnt[i]++; end
      if (m_cnt[i] == N) begin
        best = 0;
        for (int j = 1; j < N; j++)
          if ($signed(m_sc[i][j]) > $signed(m_sc[i][best])) best = j;
        m_dig[i] = 4'(best); m_max[i] = m_sc[i][best];
        m_done[i] = 1'b1; m_st[i] = 2;
      end else if (cyc - m_start[i] == tov[i]) begin
        m_st[i] = 0; m_to[i] = 1'b1; m_dig[i] = 4'hF; m_max[i] = '0;
      end
    end
  endtask

  task automatic tick();
    logic [70:0] act, exp;
    logic [SW-1:0] rexp;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      rexp = (ridx < N) ? m_sc[i][ridx] : '0;
      exp  = {m_dig[i], m_max[i], m_done[i], m_st[i] == 1, m_to[i], rexp};
      if (i == 0) act = {ifa.digit, ifa.max_score, ifa.done, ifa.busy, ifa.timeout, ifa.rd_score};
      else        act = {ifb.digit, ifb.max_score, ifb.done, ifb.busy, ifb.timeout, ifb.rd_score};
      chk(i == 0 ? "cycle_a" : "cycle_b", {57'd0, act}, {57'd0, exp});
    end
    dcnt[0] += int'(ifa.done);    dcnt[1] += int'(ifb.done);
    tcnt[0] += int'(ifa.timeout); tcnt[1] += int'(ifb.timeout);
  endtask

  task automatic send(input logic [SW-1:0] v);
    rv = 1'b1; res = v; tick(); rv = 1'b0;
  endtask

  task automatic start_frame();
    fs = 1'b1; tick(); fs = 1'b0;
  endtask

  typedef struct {
    logic [3:0]    idx;
    logic [SW-1:0] exp;
  } rd_vec_t;

  rd_vec_t       rtab [12];
  logic [SW-1:0] f1 [N];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    f1 = '{32'd5, 32'hFFFF_FFFD, 32'd12, 32'd7, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FF9C};
    for (int k = 0; k < N; k++) rtab[k] = '{4'(k), f1[k]};
    rtab[10] = '{4'd10, 32'd0};
    rtab[11] = '{4'd15, 32'd0};

    for (int i = 0; i < 2; i++) begin model_reset(i); dcnt[i] = 0; tcnt[i] = 0; end
    rst_n = 1'b0; fs = 1'b0; rv = 1'b0; res = '0; ridx = '0;
    repeat (3) tick();
    chk("reset_outputs", {ifa.digit, ifa.max_score, ifa.done, ifa.busy, ifa.timeout},
        {4'hF, 32'd0, 3'b000});
    rst_n = 1'b1;
    tick();

    // Basic frame, consecutive valids
    start_frame();
    chk("busy_after_start", ifa.busy, 1'b1);
    for (int k = 0; k < N; k++) send(f1[k]);
    chk("basic_done", {ifa.done, ifa.digit, ifa.max_score, ifa.busy}, {1'b1, 4'd2, 32'd12, 1'b0});
    tick();
    chk("basic_done_single", ifa.done, 1'b0);
    foreach (rtab[k]) begin
      ridx = rtab[k].idx; #1;
      chk("readback", ifa.rd_score, rtab[k].exp);
    end
    ridx = '0;

    // All-equal negative scores with long gaps
    start_frame();
    for (int k = 0; k < N; k++) begin repeat (100) tick(); send(32'hFFFF_FFF9); end
    chk("tie_negative", {ifa.done, ifa.digit, ifa.max_score}, {1'b1, 4'd0, 32'hFFFF_FFF9});

    // Short-timeout instance: abandoned frame
    dcnt[1] = 0;
    start_frame();
    t0 = cyc;
    chk("to_busy_rise", ifb.busy, 1'b1);
    send(32'd11); send(32'd22); send(32'd33); send(32'd44);
    for (int k = 0; k < 100 && !ifb.timeout; k++) tick();
    chk("to_latency", {ifb.timeout, 32'(cyc - t0)}, {1'b1, 32'd50});
    chk("to_outputs", {ifb.digit, ifb.max_score, ifb.busy, 32'(dcnt[1])}, {4'hF, 32'd0, 1'b0, 32'd0});
    ridx = 4'd3; #1;
    chk("to_readback", ifb.rd_score, 32'd44);
    ridx = '0;

    // Restart coincident with a valid mid-frame
    start_frame();
    send(32'd500); send(32'd600); send(32'd700);
    fs = 1'b1; rv = 1'b1; res = 32'd1000; tick(); fs = 1'b0; rv = 1'b0;
    dcnt[0] = 0;
    for (int k = 0; k < N; k++) send(k == 9 ? 32'd99 : 32'(k * 5));
    repeat (3) tick();
    chk("restart_result", {ifa.digit, ifa.max_score, 32'(dcnt[0])}, {4'd9, 32'd99, 32'd1});

    // Extra valids in DONE are ignored
    dcnt[0] = 0;
    for (int k = 0; k < 11; k++) send(32'd5000);
    chk("done_ignores_valid", {ifa.digit, ifa.max_score, 32'(dcnt[0])}, {4'd9, 32'd99, 32'd0});

    // Reset mid-frame
    start_frame();
    for (int k = 0; k < 6; k++) send(32'(100 + k));
    dcnt[0] = 0; tcnt[0] = 0;
    rst_n = 1'b0; #1;
    chk("async_reset", {ifa.digit, ifa.max_score, ifa.done, ifa.busy, ifa.timeout, ifa.rd_score},
        {4'hF, 32'd0, 3'b000, 32'd0});
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 11; k++) send(32'd777);
    chk("idle_ignores_valid", {ifa.digit, ifa.busy, 32'(dcnt[0] + tcnt[0])}, {4'hF, 1'b0, 32'd0});
    start_frame();
    for (int k = 0; k < N; k++) send(32'(k + 1));
    chk("clean_after_reset", {ifa.done, ifa.digit, ifa.max_score}, {1'b1, 4'd9, 32'd10});

    // Randomized traffic, both instances checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom % 600) != 0;
      fs    = ($urandom % 40) == 0;
      rv    = ((n / 500) % 2 == 1) ? (($urandom % 8) == 0) : (($urandom % 2) == 0);
      res   = (($urandom % 4) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : 32'($urandom);
      ridx  = 4'($urandom % 16);
      tick();
    end
    fs = 1'b0; rv = 1'b0; rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/mnist_result_collector.md
MNIST_RESULT_COLLECTOR -- requirements
Module: mnist_result_collector

Interface
REQ-001 Parameter NUM_CLASSES, default 10: number of class scores per frame.
REQ-002 Parameter SCORE_WIDTH, default 32: width of each signed class score.
REQ-003 Parameter TIMEOUT_CYCLES, default 5000000: maximum cycles allowed in COLLECT before the frame is abandoned.
REQ-004 Clocking SHALL be one clock, clk; reset SHALL be asynchronous and active-low, rst_n.
REQ-005 clk  input  1  system clock, all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 frame_start  input  1  single-cycle pulse: a new image is entering the network core; arms collection.
REQ-008 result  input  SCORE_WIDTH  class score from network core, two's complement.
REQ-009 result_valid  input  1  qualifies result for one cycle; no backpressure.
REQ-010 digit  output  4  predicted class index; 4'hF when no valid prediction.
REQ-011 max_score  output  SCORE_WIDTH  score of predicted class.
REQ-012 done  output  1  one-cycle pulse: digit/max_score updated for a complete frame.
REQ-013 busy  output  1  high while in COLLECT.
REQ-014 timeout  output  1  one-cycle pulse: frame abandoned after TIMEOUT_CYCLES.
REQ-015 rd_idx  input  4  readback select of stored class score.
REQ-016 rd_score  output  SCORE_WIDTH  combinational readback of score[rd_idx]; 0 when rd_idx >= NUM_CLASSES.

Function
REQ-017 FSM SHALL have states IDLE, COLLECT, DONE; state encoding free.
REQ-018 IDLE: result_valid ignored; frame_start -> COLLECT.
REQ-019 On frame_start (any state): count, timer, running max cleared; scores array left intact until overwritten; busy high from next cycle.
REQ-020 COLLECT: each result_valid cycle stores result into score[count], count increments by 1.
REQ-021 Running argmax: first score of frame loads max unconditionally; later score replaces max only if strictly greater (signed compare); ties keep lower index.
REQ-022 On the cycle the NUM_CLASSES-th result_valid is sampled: next cycle state=DONE, done=1 for exactly one cycle, digit/max_score show final argmax including that last score.
REQ-023 DONE: digit, max_score held stable; extra result_valid ignored; frame_start -> COLLECT (digit/max_score held until next done or timeout).
REQ-024 frame_start and result_valid in same cycle: frame_start wins, that result discarded, count=0.
REQ-025 Timer counts every COLLECT cycle from 0; when it reaches TIMEOUT_CYCLES-1 without completion: next cycle state=IDLE, timeout=1 one cycle, digit=4'hF, max_score=0, done stays 0.
REQ-026 If the final result_valid coincides with timer reaching TIMEOUT_CYCLES-1, completion wins: done pulses, timeout does not.
REQ-027 done and timeout SHALL never be high in the same cycle.
REQ-028 count SHALL never exceed NUM_CLASSES; no writes to score[] outside COLLECT.
REQ-029 Timer width SHALL be clog2(TIMEOUT_CYCLES) bits, saturating never (cleared on exit from COLLECT).

Reset
REQ-030 While rst_n=0: state=IDLE, digit=4'hF, max_score=0, done=0, busy=0, timeout=0, count=0, timer=0, all score[] =0.
REQ-031 Reset asserted mid-COLLECT SHALL abort immediately with no done or timeout pulse; first frame_start after release starts a clean frame.

Verification
REQ-032 Reset, frame_start, scores 5,-3,12,7,0,1,2,3,4,-100 on consecutive cycles -> done one cycle after 10th valid, digit=2, max_score=12, busy low after done.
REQ-033 Scores all -7 with gaps of 100 idle cycles between valids -> digit=0, max_score=-7 (tie to lowest index, signed handled).
REQ-034 TIMEOUT_CYCLES=50, frame_start then only 4 valids -> timeout pulse 50 cycles after busy rises, digit=4'hF, no done; rd_idx=3 returns 4th score.
REQ-035 frame_start coincident with a result_valid mid-frame, then 10 fresh scores with max 99 at index 9 -> digit=9, done exactly once.
REQ-036 rst_n low after 6 valids -> all outputs at reset values, no pulses; 11 valids in DONE/IDLE without frame_start -> no done, digit unchanged.
